bin_to_gray_counter: RTL and testbench
======================================

Name: bin_to_gray_counter

Overview:
- Binary up/down counter with a registered Gray-code output.
- It is the encode side matching the team's Gray-to-binary decoder: it generates Gray sequences (one bit change per step) that feed the decoder and any cross-domain pointer logic.
- Binary and Gray registers update on the same edge, so both outputs always describe the same count.
- Provides synchronous load, count enable, direction select and a wrap pulse.

Parameters:
WIDTH, 4, counter and code width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; one step per cycle while high
up_dn  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe; overrides en
load_bin  input  WIDTH  binary value loaded when load=1
bin  output  WIDTH  registered binary count
gray  output  WIDTH  registered Gray code of bin
wrap  output  1  one-cycle pulse after a wrap-around step
step  output  1  one-cycle pulse after any count step (not load)

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - bin=0, gray=0, wrap=0, step=0.
  - Counting resumes on the first rising edge after rst_n deasserts.
- Reset asserted mid-count clears all outputs immediately, without waiting for a clock edge.
- Next-state priority, evaluated at each rising edge:
  1. load=1: bin<=load_bin; gray<=load_bin^(load_bin>>1); step<=0; wrap<=0. The values of en and up_dn are ignored.
  2. else en=1, up_dn=1: bin<=bin+1, modulo 2^WIDTH.
  3. else en=1, up_dn=0: bin<=bin-1, modulo 2^WIDTH.
  4. else: bin and gray hold; step<=0; wrap<=0.
- Gray is computed from the next binary value, never from the current bin:
  - gray <= next_bin ^ (next_bin >> 1), registered in the same edge as bin.
  - Invariant checked every cycle: gray == bin ^ (bin >> 1).
  - No Gray register is derived from a delayed bin, so there is zero cycle skew between the two outputs.
- Latency: a change on en/up_dn/load is visible on bin/gray after exactly 1 clock.
- step: 1 for the cycle following every edge where a count step occurred (cases 2 and 3), else 0.
- wrap: 1 for one cycle after these steps, else 0:
  - up step from 2^WIDTH-1 to 0;
  - down step from 0 to 2^WIDTH-1.
- A load of any value, including 0 or max, never asserts wrap or step.
- Continuous counting: each step changes exactly one bit of gray, including across the wrap boundary. Loads may change multiple bits.
- Direction reversal on consecutive cycles is legal. Each step uses up_dn as sampled on that edge.
- No combinational path from any input to any output. All outputs come straight from flops.

Test Plan:
- Reset with inputs idle -> bin=0, gray=0, wrap=0, step=0. Assert rst_n=0 between clock edges while counting -> outputs read 0 before the next edge.
- WIDTH=4, en=1, up_dn=1, 16 cycles from 0:
  - gray runs 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000;
  - wrap=1 only on the cycle after bin returns to 0;
  - step=1 on all 16 cycles;
  - exactly one gray bit changes per step.
- Count down from 0 with en=1, up_dn=0 -> next bin=15, gray=1000, wrap=1. Next step gives bin=14, gray=1001, wrap=0.
- load=1, load_bin=1011 with en=1 -> next bin=1011, gray=1110, step=0, wrap=0. Then load=0, en=1, up_dn=1 -> bin=1100, gray=1010.
- en=0 for 5 cycles with up_dn toggling -> bin/gray frozen, step=0, wrap=0. Then alternate up_dn each cycle from bin=7 -> bin 8,7,8,7; gray 1100,0100,1100,0100.
- load_bin=1111 loaded while up_dn=1 -> no wrap on the load cycle; the following up step gives bin=0 with wrap=1.

Source files
------------

// File: rtl/bin_to_gray_counter.sv
// Binary up/down counter with a registered Gray-code output. The binary and
// Gray registers load on the same edge, so both outputs always describe one count.
module bin_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             step
);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  op_e              op;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;
  logic             next_step;

  // Load beats count enable; direction only matters while counting.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up_dn ? OP_UP : OP_DOWN;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    next_bin  = bin;
    next_wrap = 1'b0;
    next_step = 1'b0;
    unique case (op)
      OP_LOAD: next_bin = load_bin;
      OP_UP: begin
        next_bin  = bin + ONE;
        next_step = 1'b1;
        next_wrap = (bin == MAX_COUNT);
      end
      OP_DOWN: begin
        next_bin  = bin - ONE;
        next_step = 1'b1;
        next_wrap = (bin == '0);
      end
      default: ;
    endcase
  end

  // Gray is encoded from the value about to be stored, not from the current
  // bin, so there is no cycle of skew between the two outputs.
  assign next_gray = next_bin ^ (next_bin >> 1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
      step <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= next_gray;
      wrap <= next_wrap;
      step <= next_step;
    end
  end

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Scoreboard bench for bin_to_gray_counter: stimulus pushes hand-computed
// expectations, a monitor pops one per clock edge and compares.
module tb_bin_to_gray_counter;

  localparam int WIDTH = 4;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;
    logic             step;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;
  logic             step;

  exp_t             sb[$];
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] gtab[16];
  int               n_tests;
  int               n_fail;

  bin_to_gray_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the result
  // expected after the following rising edge.
  task automatic apply(input string name, input logic i_en, input logic i_up,
                       input logic i_load, input logic [WIDTH-1:0] i_lbin,
                       input logic [WIDTH-1:0] e_bin, input logic [WIDTH-1:0] e_gray,
                       input logic e_wrap, input logic e_step);
    exp_t e;
    @(negedge clk);
    en       = i_en;
    up_dn    = i_up;
    load     = i_load;
    load_bin = i_lbin;
    e.name = name;
    e.bin  = e_bin;
    e.gray = e_gray;
    e.wrap = e_wrap;
    e.step = e_step;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    check("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk) prev_gray = gray;

  // Monitor: every rising edge presents a new output word.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, "_bin"},  bin,  e.bin);
      check({e.name, "_gray"}, gray, e.gray);
      check({e.name, "_wrap"}, wrap, e.wrap);
      check({e.name, "_step"}, step, e.step);
      if (e.step) check({e.name, "_onebit"}, $countones(gray ^ prev_gray), 1);
    end
  end

  initial begin
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b0;
    load     = 1'b0;
    load_bin = '0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_bin",  bin,  0);
    check("rst_gray", gray, 0);
    check("rst_wrap", wrap, 0);
    check("rst_step", step, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full up cycle from 0, wrapping back to 0 on the 16th step.
    for (int i = 1; i <= 16; i++)
      apply("up", 1, 1, 0, 4'h0, 4'(i % 16), gtab[i % 16], i == 16, 1);

    apply("dn_wrap", 1, 0, 0, 4'h0, 4'd15, 4'b1000, 1, 1);
    apply("dn",      1, 0, 0, 4'h0, 4'd14, 4'b1001, 0, 1);

    apply("load_b",  1, 1, 1, 4'b1011, 4'b1011, 4'b1110, 0, 0);
    apply("up_ld",   1, 1, 0, 4'h0,    4'b1100, 4'b1010, 0, 1);

    for (int i = 0; i < 5; i++)
      apply("hold", 0, 1'(i % 2), 0, 4'h0, 4'b1100, 4'b1010, 0, 0);

    apply("load_7",  0, 0, 1, 4'd7, 4'd7, 4'b0100, 0, 0);
    apply("alt_up0", 1, 1, 0, 4'h0, 4'd8, 4'b1100, 0, 1);
    apply("alt_dn0", 1, 0, 0, 4'h0, 4'd7, 4'b0100, 0, 1);
    apply("alt_up1", 1, 1, 0, 4'h0, 4'd8, 4'b1100, 0, 1);
    apply("alt_dn1", 1, 0, 0, 4'h0, 4'd7, 4'b0100, 0, 1);

    apply("load_max", 1, 1, 1, 4'hF, 4'hF, 4'b1000, 0, 0);
    apply("up_wrap",  1, 1, 0, 4'h0, 4'h0, 4'b0000, 1, 1);
    apply("load_0",   1, 0, 1, 4'h0, 4'h0, 4'b0000, 0, 0);

    // Count a little, then reset between edges while step is high.
    apply("pre_rst0", 1, 1, 0, 4'h0, 4'd1, 4'b0001, 0, 1);
    apply("pre_rst1", 1, 1, 0, 4'h0, 4'd2, 4'b0011, 0, 1);
    drain();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_bin",  bin,  0);
    check("async_rst_gray", gray, 0);
    check("async_rst_wrap", wrap, 0);
    check("async_rst_step", step, 0);
    #1;
    rst_n = 1'b1;
    apply("post_rst0", 1, 1, 0, 4'h0, 4'd1, 4'b0001, 0, 1);
    apply("post_rst1", 1, 1, 0, 4'h0, 4'd2, 4'b0011, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
